// File: rtl/inpass_pkg.sv
// Shared constants for the N-channel fabric input-pass BEL.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Mode encoding per channel: 00 bypass, 01 one register stage,
// 10 two register stages, 11 rising-edge pulse.
package inpass_pkg;

  localparam int ConfigBitsPerChannel = 2;

  localparam logic [ConfigBitsPerChannel-1:0] MODE_BYPASS = 2'b00;
  localparam logic [ConfigBitsPerChannel-1:0] MODE_REG1   = 2'b01;
  localparam logic [ConfigBitsPerChannel-1:0] MODE_REG2   = 2'b10;
  localparam logic [ConfigBitsPerChannel-1:0] MODE_EDGE   = 2'b11;

endpackage

// File: rtl/inpass_channel.sv
// One input-pass channel: bypass, 1-stage, 2-stage or rising-edge pulse output.
// Latency: 0 (bypass), 1 (REG1 / EDGE), 2 (REG2) UserCLK edges.
// Backpressure: none; CE low freezes both stages, and with them every registered output.
// Ports: UserCLK clock, RST sync active-high reset, CE stage enable,
//        I channel input, Mode 2-bit select, O channel output.
module inpass_channel
  import inpass_pkg::*;
(
  input  logic                            UserCLK,
  input  logic                            RST,
  input  logic                            CE,
  input  logic                            I,
  input  logic [ConfigBitsPerChannel-1:0] Mode,
  output logic                            O
);

  logic stage1;
  logic stage2;
  logic edgeDet;
  logic muxLo;
  logic muxHi;

  // Stages clock in every mode so a mode switch exposes live history at once.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
    end else if (CE) begin
      stage1 <= I;
      stage2 <= stage1;
    end
  end

  // Rising edge = newest sample high, previous sample low. With CE low the
  // stages hold, so a pulse that is high stays high until CE returns.
  assign edgeDet = stage1 & ~stage2;

  // 4:1 select from three 2:1 cells: Mode[0] picks within a pair,
  // Mode[1] picks the pair ({bypass, reg1} vs {reg2, edge}).
  my_mux2 muxLoInst (
    .A0(I),
    .A1(stage1),
    .S (Mode[0]),
    .X (muxLo)
  );

  my_mux2 muxHiInst (
    .A0(stage2),
    .A1(edgeDet),
    .S (Mode[0]),
    .X (muxHi)
  );

  my_mux2 muxOutInst (
    .A0(muxLo),
    .A1(muxHi),
    .S (Mode[1]),
    .X (O)
  );

endmodule

// File: rtl/my_mux2.sv
// Generic 2:1 mux cell, X = S ? A1 : A0.
// Latency: combinational.
// Backpressure: none.
// Ports: A0/A1 data inputs, S select, X output.
module my_mux2 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/inpass_n_frame_config.sv
// N-channel fabric input-pass BEL with per-channel mode from frame config bits.
// Latency: per channel, 0 (bypass), 1 (REG1 / EDGE) or 2 (REG2) UserCLK edges.
// Backpressure: none; shared CE low freezes all channel registers.
// Ports: UserCLK clock, RST sync active-high reset (shared), CE clock enable (shared),
//        I[NoChannels] inputs, O[NoChannels] outputs,
//        ConfigBits[NoConfigBits]: bits [2c+1:2c] hold the mode of channel c
//        (BelMap: I<c>_mode at bits 2c and 2c+1).
module inpass_n_frame_config
  import inpass_pkg::*;
#(
  parameter int NoChannels   = 4,
  // Derived from NoChannels; not meant to be overridden.
  parameter int NoConfigBits = ConfigBitsPerChannel * NoChannels
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic                    CE,
  input  logic [NoChannels-1:0]   I,
  output logic [NoChannels-1:0]   O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  for (genvar c = 0; c < NoChannels; c++) begin : genChannel
    inpass_channel channelInst (
      .UserCLK(UserCLK),
      .RST    (RST),
      .CE     (CE),
      .I      (I[c]),
      .Mode   (ConfigBits[c*ConfigBitsPerChannel +: ConfigBitsPerChannel]),
      .O      (O[c])
    );
  end

endmodule

// File: tb/tb_inpass_n_frame_config.sv
// Self-checking bench for inpass_n_frame_config at NoChannels = 32, 4 and 1.
// All three instances share stimulus on their low channels and are compared
// against one history-based reference model.
module tb_inpass_n_frame_config;
  import inpass_pkg::*;

  logic        UserCLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [31:0] I;
  logic [63:0] cfg;
  logic [31:0] o32;
  logic [3:0]  o4;
  logic        o1;

  int errors = 0;
  int checks = 0;

  // Reference history: hist[0] = newest accepted input word, hist[1] = the one before.
  logic [31:0] hist[$];

  always #5 UserCLK = ~UserCLK;

  inpass_n_frame_config #(.NoChannels(32)) dut32 (
    .UserCLK(UserCLK), .RST(RST), .CE(CE), .I(I), .O(o32), .ConfigBits(cfg)
  );

  inpass_n_frame_config #(.NoChannels(4)) dut4 (
    .UserCLK(UserCLK), .RST(RST), .CE(CE), .I(I[3:0]), .O(o4), .ConfigBits(cfg[7:0])
  );

  inpass_n_frame_config #(.NoChannels(1)) dut1 (
    .UserCLK(UserCLK), .RST(RST), .CE(CE), .I(I[0:0]), .O(o1), .ConfigBits(cfg[1:0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelOut();
    logic [31:0] r;
    logic [31:0] newest;
    logic [31:0] older;
    newest = hist[0];
    older  = hist[1];
    r      = '0;
    for (int c = 0; c < 32; c++) begin
      case (cfg[2*c +: 2])
        MODE_BYPASS: r[c] = I[c];
        MODE_REG1:   r[c] = newest[c];
        MODE_REG2:   r[c] = older[c];
        default:     r[c] = newest[c] & ~older[c];
      endcase
    end
    return r;
  endfunction

  // One rising edge: reset clears history, CE accepts a new sample, else hold.
  task automatic tick();
    @(posedge UserCLK);
    if (RST) begin
      hist = '{32'h0, 32'h0};
    end else if (CE) begin
      hist.push_front(I);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] e;
    e = modelOut();
    chk({tag, "/n32"}, o32, e);
    chk({tag, "/n4"}, 32'(o4), 32'(e[3:0]));
    chk({tag, "/n1"}, 32'(o1), 32'(e[0]));
  endtask

  task automatic setMode(input int c, input logic [1:0] m);
    cfg[2*c +: 2] = m;
  endtask

  initial begin
    int pulses;
    int first;

    hist = '{32'h0, 32'h0};

    // Reset with bypass: outputs follow I; switching to REG1 under reset gives 0.
    RST = 1'b1;
    CE  = 1'b1;
    I   = 32'h0000_000A;
    cfg = '0;
    #1;
    chk("rst_bypass", 32'(o4), 32'h0000_000A);
    tick();
    cfg = {32{MODE_REG1}};
    #1;
    chk("rst_reg1", 32'(o4), 32'h0);
    checkAll("rst");

    // Latency: channel 0 REG1, channel 1 REG2.
    RST = 1'b0;
    cfg = '0;
    setMode(0, MODE_REG1);
    setMode(1, MODE_REG2);
    I = '0;
    tick();
    tick();
    checkAll("lat_idle");
    I = 32'h3;
    tick();
    chk("lat_reg1_k", 32'(o4[0]), 32'd1);
    chk("lat_reg2_k", 32'(o4[1]), 32'd0);
    tick();
    chk("lat_reg2_k1", 32'(o4[1]), 32'd1);
    checkAll("lat");

    // EDGE: held-high input gives exactly one pulse, on the sampling edge.
    setMode(2, MODE_EDGE);
    I[2] = 1'b0;
    tick();
    tick();
    I[2] = 1'b1;
    pulses = 0;
    first  = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o4[2]) begin
        pulses++;
        if (first < 0) first = k;
      end
      checkAll("edge_hold");
    end
    chk("edge_pulses", 32'(pulses), 32'd1);
    chk("edge_first", 32'(first), 32'd0);

    // EDGE with input toggling every cycle: pulse every other cycle.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      I[2] = k[0];
      tick();
      chk("edge_toggle", 32'(o4[2]), 32'(k % 2));
      if (o4[2]) pulses++;
    end
    chk("edge_toggle_cnt", 32'(pulses), 32'd4);

    // CE hold on REG2 while I toggles.
    I[1] = 1'b1;
    tick();
    tick();
    chk("ce_pre", 32'(o4[1]), 32'd1);
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      I[1] = ~I[1];
      tick();
      chk("ce_hold_reg2", 32'(o4[1]), 32'd1);
    end
    CE = 1'b1;
    I[1] = 1'b1;

    // EDGE pulse frozen high while CE is low, cleared one edge after CE returns.
    I[2] = 1'b0;
    tick();
    tick();
    chk("ce_edge_idle", 32'(o4[2]), 32'd0);
    I[2] = 1'b1;
    tick();
    chk("ce_edge_pulse", 32'(o4[2]), 32'd1);
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ce_edge_frozen", 32'(o4[2]), 32'd1);
    end
    CE = 1'b1;
    tick();
    chk("ce_edge_release", 32'(o4[2]), 32'd0);
    checkAll("ce");

    // Mid-stream reset with I held high on REG2 (ch1) and EDGE (ch2).
    I[1] = 1'b1;
    I[2] = 1'b1;
    tick();
    tick();
    chk("mrst_pre", 32'(o4[1]), 32'd1);
    RST = 1'b1;
    tick();
    chk("mrst_reg2_clr", 32'(o4[1]), 32'd0);
    chk("mrst_edge_clr", 32'(o4[2]), 32'd0);
    RST = 1'b0;
    tick();
    chk("mrst_reg2_e1", 32'(o4[1]), 32'd0);
    chk("mrst_edge_e1", 32'(o4[2]), 32'd1);
    tick();
    chk("mrst_reg2_e2", 32'(o4[1]), 32'd1);
    chk("mrst_edge_e2", 32'(o4[2]), 32'd0);
    tick();
    chk("mrst_edge_e3", 32'(o4[2]), 32'd0);
    checkAll("mrst");

    // Random sweep: modes, inputs, CE and RST against the reference model.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 63) == 0) cfg = {$urandom, $urandom};
      I   = $urandom;
      CE  = ($urandom_range(0, 4) != 0);
      RST = ($urandom_range(0, 19) == 0);
      #1;
      checkAll("rnd_comb");
      tick();
      checkAll("rnd_seq");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
